// File: rtl/tc_sram_banked_pkg.sv
// rtl/tc_sram_banked_pkg.sv - shared constants, address split helpers and response type
package tc_sram_banked_pkg;

  localparam int unsigned DefNumBanks  = 4;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned BankSel      = $clog2(DefNumBanks);

  // One read response as seen by a requester.
  typedef struct packed {
    logic                    valid;
    logic [DefDataWidth-1:0] data;
  } rsp_t;

  // Low address bits select the bank; with zero select bits every word is bank 0.
  function automatic int unsigned bank_idx(input int unsigned addr, input int unsigned bank_sel);
    return addr & ((32'd1 << bank_sel) - 32'd1);
  endfunction

  // Remaining upper bits select the row inside the bank.
  function automatic int unsigned row_idx(input int unsigned addr, input int unsigned bank_sel);
    return addr >> bank_sel;
  endfunction

endpackage

// File: rtl/tc_sram_banked_if.sv
// rtl/tc_sram_banked_if.sv - request/response bus bundle for all ports of the banked SRAM
interface tc_sram_banked_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BeWidth   = 8
);

  logic [NumPorts-1:0]                req;
  logic [NumPorts-1:0]                gnt;
  logic [NumPorts-1:0]                we;
  logic [NumPorts-1:0][AddrWidth-1:0] addr;
  logic [NumPorts-1:0][DataWidth-1:0] wdata;
  logic [NumPorts-1:0][BeWidth-1:0]   be;
  logic [NumPorts-1:0]                rvalid;
  logic [NumPorts-1:0][DataWidth-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/tc_rr_bank_arb.sv
// rtl/tc_rr_bank_arb.sv - round-robin arbiter with priority pointer for one bank
module tc_rr_bank_arb #(
  parameter int unsigned NumPorts = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req,
  output logic [NumPorts-1:0] gnt
);

  localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  // Scan upward from the pointer with wrap; the first requester wins and the
  // pointer moves just past it. Nothing is granted while reset is held.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (rst_ni) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (32'(ptr_q) + i >= NumPorts) begin
          idx = PtrW'(32'(ptr_q) + i - NumPorts);
        end else begin
          idx = PtrW'(32'(ptr_q) + i);
        end
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = (32'(idx) == NumPorts - 1) ? '0 : PtrW'(32'(idx) + 1);
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tc_sram_banked.sv
// rtl/tc_sram_banked.sv - word-interleaved multi-bank SRAM with per-bank arbitration and pipelined reads
module tc_sram_banked
  import tc_sram_banked_pkg::*;
#(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  parameter string       SimInit   = "none",
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input logic             clk_i,
  input logic             rst_ni,
  tc_sram_banked_if.slave bus
);

  localparam int unsigned BankBits = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int unsigned BankW    = (BankBits > 0) ? BankBits : 1;
  localparam int unsigned Rows     = NumWords / NumBanks;
  localparam int unsigned RowW     = (Rows > 1) ? $clog2(Rows) : 1;
  // Only all-ones and all-zeros power-up patterns are distinguished; other
  // choices start the array at zero.
  localparam logic [DataWidth-1:0] InitWord = (SimInit == "ones") ? {DataWidth{1'b1}} : '0;

  logic [DataWidth-1:0] mem [NumBanks][Rows] = '{default: '{default: InitWord}};

  logic [NumPorts-1:0][BankW-1:0]     bank_sel;
  logic [NumPorts-1:0][RowW-1:0]      row_sel;
  logic [NumPorts-1:0]                in_range;
  logic [NumPorts-1:0]                gnt;
  logic [NumPorts-1:0][DataWidth-1:0] wmask;
  logic [NumPorts-1:0][DataWidth-1:0] rd_word;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_req;
  logic [NumBanks-1:0][NumPorts-1:0]  bank_gnt;

  // Read pipeline: stage 0 captures the array at the grant edge, later stages shift.
  logic [NumPorts-1:0][Latency-1:0]                st_valid;
  logic [NumPorts-1:0][Latency-1:0][DataWidth-1:0] st_data;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [AddrWidth-1:0] addr;
    logic [BeWidth-1:0]   be;

    assign addr         = bus.addr[p];
    assign be           = bus.be[p];
    assign bank_sel[p]  = BankW'(bank_idx(32'(addr), BankBits));
    assign row_sel[p]   = RowW'(row_idx(32'(addr), BankBits));
    assign in_range[p]  = (32'(addr) < NumWords);

    for (genvar k = 0; k < DataWidth; k++) begin : g_mask
      assign wmask[p][k] = be[k / ByteWidth];
    end

    // Out-of-range words read as zero without touching the array.
    assign rd_word[p]    = in_range[p] ? mem[bank_sel[p]][row_sel[p]] : '0;
    assign gnt[p]        = bank_gnt[bank_sel[p]][p];
    assign bus.rvalid[p] = st_valid[p][Latency-1];
    assign bus.rdata[p]  = st_data[p][Latency-1];
  end

  assign bus.gnt = gnt;

  // Route each request to the arbiter of the bank it addresses.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = bus.req[p] && (bank_sel[p] == BankW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    tc_rr_bank_arb #(
      .NumPorts(NumPorts)
    ) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );
  end

  // Byte-masked writes; at most one port wins each bank, so writes never collide.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (gnt[p] && bus.we[p] && in_range[p]) begin
        mem[bank_sel[p]][row_sel[p]] <= (mem[bank_sel[p]][row_sel[p]] & ~wmask[p])
                                      | (bus.wdata[p] & wmask[p]);
      end
    end
  end

  // Response pipeline; each stage's data only moves with a valid so the
  // output holds its last read between pulses. Reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_valid <= '0;
      st_data  <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        st_valid[p][0] <= gnt[p] && !bus.we[p];
        if (gnt[p] && !bus.we[p]) begin
          st_data[p][0] <= rd_word[p];
        end
        for (int i = 1; i < Latency; i++) begin
          st_valid[p][i] <= st_valid[p][i-1];
          if (st_valid[p][i-1]) begin
            st_data[p][i] <= st_data[p][i-1];
          end
        end
      end
    end
  end

endmodule
